// File: rtl/key_debouncer.sv
// Three-button debouncer: 2-flop synchronizers, per-button millisecond debounce counters,
// and a one-cycle registered press code with U > L > R priority.
module key_debouncer #(
   parameter int unsigned DEBOUNCE_MS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       one_ms_tick,
   input  logic       btnU,
   input  logic       btnL,
   input  logic       btnR,
   output logic [1:0] key_code
);

   localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_MS - 1);

   // Bit 2 = up, bit 1 = left, bit 0 = right.
   logic [2:0] raw;
   logic [2:0] sync1_q, sync2_q;
   logic [2:0] stable_q, stable_d;
   logic [2:0] press;
   logic [7:0] cnt_q [3];
   logic [7:0] cnt_d [3];
   logic [1:0] code_d;

   assign raw = {btnU, btnL, btnR};

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = 8'd0;
         end else if (one_ms_tick) begin
            // Terminal tick: adopt the new level and restart, so the count never wraps.
            if (cnt_q[i] >= LAST_CNT) begin
               stable_d[i] = sync2_q[i];
               cnt_d[i]    = 8'd0;
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end

      press = stable_d & ~stable_q;

      if (press[2]) begin
         code_d = 2'b01;
      end else if (press[1]) begin
         code_d = 2'b10;
      end else if (press[0]) begin
         code_d = 2'b11;
      end else begin
         code_d = 2'b00;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 3'b000;
         sync2_q  <= 3'b000;
         stable_q <= 3'b000;
         key_code <= 2'b00;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= 8'd0;
         end
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         key_code <= code_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer: one DUT with a 20-tick debounce, one with a 1-tick debounce.
module tb_key_debouncer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       one_ms_tick = 1'b0;
   logic       btnU = 1'b0;
   logic       btnL = 1'b0;
   logic       btnR = 1'b0;
   logic [1:0] k20;
   logic [1:0] k1;

   int vectors = 0;
   int miscompares = 0;

   int         ev20, ev20_r, ev20_tick, ev20_dly, ev1;
   logic [1:0] ev20_code;
   int         tick_count, since_tick;

   key_debouncer #(.DEBOUNCE_MS(20)) u_dut20 (
      .clk         (clk),
      .rst         (rst),
      .one_ms_tick (one_ms_tick),
      .btnU        (btnU),
      .btnL        (btnL),
      .btnR        (btnR),
      .key_code    (k20)
   );

   key_debouncer #(.DEBOUNCE_MS(1)) u_dut1 (
      .clk         (clk),
      .rst         (rst),
      .one_ms_tick (one_ms_tick),
      .btnU        (btnU),
      .btnL        (btnL),
      .btnR        (btnR),
      .key_code    (k1)
   );

   always #5 clk = ~clk;

   task clear_ev();
      ev20 = 0; ev20_r = 0; ev20_tick = -1; ev20_dly = -1; ev1 = 0;
      ev20_code = 2'b00; tick_count = 0; since_tick = 0;
   endtask

   // One clock cycle; outputs are sampled 1 time unit after the rising edge.
   task step(input logic t);
      @(negedge clk);
      one_ms_tick = t;
      @(posedge clk);
      #1;
      if (t) begin
         tick_count++;
         since_tick = 0;
      end else begin
         since_tick++;
      end
      if (k20 !== 2'b00) begin
         ev20++;
         ev20_code = k20;
         ev20_tick = tick_count;
         ev20_dly  = since_tick;
         if (k20 === 2'b11) ev20_r++;
      end
      if (k1 !== 2'b00) ev1++;
   endtask

   task ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         repeat (3) step(1'b0);
      end
   endtask

   task settle();
      repeat (3) step(1'b0);
   endtask

   task do_reset();
      @(negedge clk);
      rst = 1'b1; btnU = 1'b0; btnL = 1'b0; btnR = 1'b0; one_ms_tick = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      settle();
      clear_ev();
   endtask

   task test_reset();
      #1;
      vectors++;
      if (k20 !== 2'b00) begin
         miscompares++; $display("FAIL reset_k20: got %b want 00", k20);
      end
      vectors++;
      if (k1 !== 2'b00) begin
         miscompares++; $display("FAIL reset_k1: got %b want 00", k1);
      end
      do_reset();
   endtask

   task test_press_left();
      do_reset();
      btnL = 1'b1;
      settle();
      ticks(25);
      vectors++;
      if (ev20 !== 1) begin
         miscompares++; $display("FAIL left_count: got %0d want 1", ev20);
      end
      vectors++;
      if (ev20_code !== 2'b10) begin
         miscompares++; $display("FAIL left_code: got %b want 10", ev20_code);
      end
      vectors++;
      if (ev20_tick !== 20) begin
         miscompares++; $display("FAIL left_tick: got %0d want 20", ev20_tick);
      end
      vectors++;
      if (ev20_dly !== 0) begin
         miscompares++; $display("FAIL left_delay: got %0d want 0", ev20_dly);
      end
   endtask

   task test_glitch();
      do_reset();
      btnR = 1'b1;
      settle();
      ticks(5);
      btnR = 1'b0;
      settle();
      ticks(25);
      vectors++;
      if (ev20 !== 0) begin
         miscompares++; $display("FAIL glitch_count: got %0d want 0", ev20);
      end
      // A fresh press must need the full count again.
      clear_ev();
      btnR = 1'b1;
      settle();
      ticks(25);
      vectors++;
      if (ev20 !== 1 || ev20_code !== 2'b11) begin
         miscompares++;
         $display("FAIL glitch_repress: got %0d events code %b want 1 code 11", ev20, ev20_code);
      end
      vectors++;
      if (ev20_tick !== 20) begin
         miscompares++; $display("FAIL glitch_repress_tick: got %0d want 20", ev20_tick);
      end
   endtask

   task test_simultaneous();
      do_reset();
      btnU = 1'b1;
      btnR = 1'b1;
      settle();
      ticks(30);
      vectors++;
      if (ev20 !== 1) begin
         miscompares++; $display("FAIL simul_count: got %0d want 1", ev20);
      end
      vectors++;
      if (ev20_code !== 2'b01) begin
         miscompares++; $display("FAIL simul_code: got %b want 01", ev20_code);
      end
      vectors++;
      if (ev20_r !== 0) begin
         miscompares++; $display("FAIL simul_right_events: got %0d want 0", ev20_r);
      end
   endtask

   task test_release_repress();
      do_reset();
      btnL = 1'b1;
      settle();
      ticks(20);
      vectors++;
      if (ev20 !== 1 || ev20_code !== 2'b10) begin
         miscompares++;
         $display("FAIL rr_first: got %0d events code %b want 1 code 10", ev20, ev20_code);
      end
      clear_ev();
      btnL = 1'b0;
      settle();
      ticks(30);
      vectors++;
      if (ev20 !== 0) begin
         miscompares++; $display("FAIL rr_release: got %0d events want 0", ev20);
      end
      clear_ev();
      btnL = 1'b1;
      settle();
      ticks(25);
      vectors++;
      if (ev20 !== 1 || ev20_code !== 2'b10) begin
         miscompares++;
         $display("FAIL rr_second: got %0d events code %b want 1 code 10", ev20, ev20_code);
      end
      vectors++;
      if (ev20_tick !== 20) begin
         miscompares++; $display("FAIL rr_second_tick: got %0d want 20", ev20_tick);
      end
   endtask

   task test_reset_mid();
      do_reset();
      btnL = 1'b1;
      settle();
      ticks(10);
      vectors++;
      if (ev20 !== 0) begin
         miscompares++; $display("FAIL rmid_pre: got %0d events want 0", ev20);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (k20 !== 2'b00) begin
            miscompares++; $display("FAIL rmid_during_%0d: got %b want 00", i, k20);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      settle();
      clear_ev();
      ticks(25);
      vectors++;
      if (ev20 !== 1 || ev20_code !== 2'b10) begin
         miscompares++;
         $display("FAIL rmid_after: got %0d events code %b want 1 code 10", ev20, ev20_code);
      end
      vectors++;
      if (ev20_tick !== 20) begin
         miscompares++; $display("FAIL rmid_tick: got %0d want 20", ev20_tick);
      end
   endtask

   task test_fast();
      do_reset();
      btnR = 1'b1;
      settle();
      vectors++;
      if (k1 !== 2'b00) begin
         miscompares++; $display("FAIL fast_pretick: got %b want 00", k1);
      end
      step(1'b1);
      vectors++;
      if (k1 !== 2'b11) begin
         miscompares++; $display("FAIL fast_event: got %b want 11", k1);
      end
      // Reset must clear the output between clock edges.
      rst = 1'b1;
      #1;
      vectors++;
      if (k1 !== 2'b00) begin
         miscompares++; $display("FAIL fast_async_rst: got %b want 00", k1);
      end
      @(negedge clk);
      rst = 1'b0;
      settle();
      step(1'b1);
      vectors++;
      if (k1 !== 2'b11) begin
         miscompares++; $display("FAIL fast_held_through_rst: got %b want 11", k1);
      end
      step(1'b0);
      vectors++;
      if (k1 !== 2'b00) begin
         miscompares++; $display("FAIL fast_one_cycle: got %b want 00", k1);
      end
      clear_ev();
      for (int i = 0; i < 5; i++) begin
         btnU = 1'b1;
         step(1'b0);
         btnU = 1'b0;
         repeat (4) step(1'b0);
         step(1'b1);
      end
      vectors++;
      if (ev1 !== 0) begin
         miscompares++; $display("FAIL fast_bounce: got %0d events want 0", ev1);
      end
   endtask

   initial begin
      clear_ev();
      test_reset();
      test_press_left();
      test_glitch();
      test_simultaneous();
      test_release_repress();
      test_reset_mid();
      test_fast();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter: DEBOUNCE_MS, default 20, number of one_ms_tick pulses a synchronized button level must stay different from its stable state before the stable state changes; legal range 1..255.
REQ-002 Port: clk  input  1  system clock (40 MHz pixel/game clock); all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous assertion and deassertion, active-high.
REQ-004 Port: one_ms_tick  input  1  single-cycle strobe, once per millisecond, from the millisecond timer.
REQ-005 Port: btnU  input  1  raw asynchronous "up/start" button, active-high.
REQ-006 Port: btnL  input  1  raw asynchronous "jump left" button, active-high.
REQ-007 Port: btnR  input  1  raw asynchronous "jump right" button, active-high.
REQ-008 Port: key_code  output  2  registered press event: 2'b00 none, 2'b01 up, 2'b10 left, 2'b11 right.

Function
REQ-009 Each button SHALL pass through its own 2-flop synchronizer; only synchronized levels (sU, sL, sR) feed later logic.
REQ-010 Each button SHALL have a stable-state flop and an 8-bit debounce counter.
REQ-011 Any clk cycle with synchronized level equal to stable state SHALL clear that button's counter to 0.
REQ-012 A cycle with level differing from stable state and one_ms_tick=1 SHALL increment the counter; without the tick the counter SHALL hold.
REQ-013 When the increment would reach DEBOUNCE_MS, the stable state SHALL take the synchronized level and the counter SHALL clear to 0 in that same edge.
REQ-014 A glitch returning to the stable level before DEBOUNCE_MS ticks SHALL produce no stable-state change.
REQ-015 A press event SHALL be the 0->1 transition of a stable state; a 1->0 transition (release) SHALL produce no event.
REQ-016 key_code SHALL be non-zero for exactly one clk cycle: the cycle immediately after the edge at which the stable state rises; otherwise 2'b00.
REQ-017 Simultaneous press events in the same cycle SHALL resolve with priority U > L > R; lower-priority events in that cycle SHALL be discarded, not queued.
REQ-018 A held button SHALL produce a single event; no auto-repeat; a new event requires debounced release then debounced press.
REQ-019 Buttons SHALL debounce independently; holding one SHALL not block events from another.
REQ-020 Counter SHALL never exceed DEBOUNCE_MS-1; no wrap-around possible.
REQ-021 Total latency from raw press (stable afterwards) to key_code event SHALL be 2 sync cycles + DEBOUNCE_MS ticks + 1 cycle, ticks counted from the first tick seen with differing level.

Reset
REQ-022 rst=1 SHALL immediately clear synchronizers, stable states, counters and key_code to 0, regardless of clk.
REQ-023 Reset mid-debounce SHALL discard partial counts; no event SHALL be emitted for that press.
REQ-024 A button held through reset release SHALL be treated as a new press: one event after DEBOUNCE_MS ticks.

Verification
REQ-025 DEBOUNCE_MS=20, btnL held steady, tick every 40000 clks -> key_code=2'b10 for exactly one cycle, one cycle after the 20th tick; 2'b00 thereafter while held.
REQ-026 btnR pulses high across 5 ticks then low -> key_code stays 2'b00; counter returns to 0.
REQ-027 btnU and btnR rise in same cycle, held -> single key_code=2'b01 event; no 2'b11 event ever for that hold.
REQ-028 btnL held, event seen, released 30 ms, pressed again -> second 2'b10 event; release alone produces none.
REQ-029 btnL held, rst asserted after 10 ticks for 3 clks, still held -> key_code 0 during reset; one 2'b10 event 20 ticks after reset release.
REQ-030 DEBOUNCE_MS=1, btnR held, one tick -> 2'b11 one cycle after that tick's edge; bounce on btnU around ticks never yields events.
